// File: rtl/rpn_eval.sv
`default_nettype none
// ============================================================================
// Module   : rpn_eval
// Purpose  : Reverse-Polish expression evaluator. Takes one ASCII character
//            per handshake from the infix-to-RPN stage, keeps a signed operand
//            stack, and on '=' prints the result as decimal ASCII followed by
//            a line feed. Error conditions print "E\n" instead.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK       in   clock, all state on the rising edge
//   RST       in   synchronous active-high reset
//   IN_STB    in   upstream character valid
//   IN_CHAR   in   [7:0] upstream ASCII character
//   IN_ACK    out  one-cycle pulse, character consumed
//   OUT_STB   out  result character valid
//   OUT_CHAR  out  [7:0] result ASCII character
//   OUT_ACK   in   downstream has taken OUT_CHAR
//   ERR       out  sticky expression-error flag
//   DEPTH     out  [3:0] operand-stack occupancy
// Parameters
//   STACK_DEPTH  operand-stack entries (DEPTH is 4 bits, so at most 15)
//   W            operand width, two's complement; decimal output covers W<=16
// ============================================================================
module rpn_eval #(
    parameter int STACK_DEPTH = 8,
    parameter int W           = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_STB,
    input  logic [7:0] IN_CHAR,
    output logic       IN_ACK,
    output logic       OUT_STB,
    output logic [7:0] OUT_CHAR,
    input  logic       OUT_ACK,
    output logic       ERR,
    output logic [3:0] DEPTH
);

    localparam int AW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW    = $clog2(W + 1);
    localparam int MW    = 17;  // magnitude of the most negative value needs one extra bit
    localparam int BUF_N = 8;   // '-' + five digits + LF fits in seven slots

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK  = 3'd1,
        ST_EXEC = 3'd2,
        ST_CONV = 3'd3,
        ST_EMIT = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [7:0]     char_q, char_d;
    logic [W-1:0]   stk_q [STACK_DEPTH];
    logic [W-1:0]   stk_d [STACK_DEPTH];
    logic [3:0]     depth_q, depth_d;
    logic           err_q, err_d;

    // divider: quo_q starts as the dividend magnitude and shifts out MSB first
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // binary-to-decimal conversion
    logic [MW-1:0]  mag_q, mag_d;
    logic [2:0]     pidx_q, pidx_d;
    logic [3:0]     dig_q, dig_d;
    logic           started_q, started_d;

    // emission buffer
    logic [7:0]     buf_q [BUF_N];
    logic [7:0]     buf_d [BUF_N];
    logic [2:0]     len_q, len_d;
    logic [2:0]     idx_q, idx_d;

    // ------------------------------------------------------------------
    // Character decode and stack access
    // ------------------------------------------------------------------
    logic           w_is_digit, w_is_arith, w_is_div, w_is_eq;
    logic [AW-1:0]  w_top_idx, w_nxt_idx, w_push_idx;
    logic [W-1:0]   w_top, w_nxt, w_arith;
    logic [W-1:0]   w_a_mag, w_b_mag;
    logic [MW-1:0]  w_top_ext;

    assign w_is_digit = (char_q >= 8'h30) && (char_q <= 8'h39);
    assign w_is_arith = (char_q == 8'h2B) || (char_q == 8'h2D) || (char_q == 8'h2A);
    assign w_is_div   = (char_q == 8'h2F);
    assign w_is_eq    = (char_q == 8'h3D);

    // indices are only used when the occupancy makes them valid
    assign w_top_idx  = AW'(depth_q - 4'd1);
    assign w_nxt_idx  = AW'(depth_q - 4'd2);
    assign w_push_idx = AW'(depth_q);

    assign w_top = stk_q[w_top_idx];
    assign w_nxt = stk_q[w_nxt_idx];

    always_comb begin
        w_arith = w_nxt * w_top;
        if (char_q == 8'h2B) begin
            w_arith = w_nxt + w_top;
        end else if (char_q == 8'h2D) begin
            w_arith = w_nxt - w_top;
        end
    end

    // unsigned magnitudes; the most negative value maps to 2^(W-1), which
    // still fits unsigned in W bits
    assign w_a_mag   = w_nxt[W-1] ? (~w_nxt + 1'b1) : w_nxt;
    assign w_b_mag   = w_top[W-1] ? (~w_top + 1'b1) : w_top;
    assign w_top_ext = {{(MW - W){w_top[W-1]}}, w_top};

    // ------------------------------------------------------------------
    // Restoring-division step
    // ------------------------------------------------------------------
    logic [W:0]     w_rsh;
    logic           w_ge;
    logic [W-1:0]   w_rem_nx, w_quo_nx, w_quo_res;

    assign w_rsh     = {rem_q, quo_q[W-1]};
    assign w_ge      = (w_rsh >= {1'b0, dvs_q});
    // when w_ge holds the difference is below the divisor, so W bits suffice
    assign w_rem_nx  = w_ge ? (w_rsh[W-1:0] - dvs_q) : w_rsh[W-1:0];
    assign w_quo_nx  = {quo_q[W-2:0], w_ge};
    assign w_quo_res = neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;

    // ------------------------------------------------------------------
    // Decimal weights
    // ------------------------------------------------------------------
    function automatic logic [MW-1:0] pow10(input logic [2:0] sel);
        case (sel)
            3'd0:    return 17'd10000;
            3'd1:    return 17'd1000;
            3'd2:    return 17'd100;
            3'd3:    return 17'd10;
            default: return 17'd1;
        endcase
    endfunction

    logic [MW-1:0]  w_pow;
    assign w_pow = pow10(pidx_q);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        char_d    = char_q;
        stk_d     = stk_q;
        depth_d   = depth_q;
        err_d     = err_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        pidx_d    = pidx_q;
        dig_d     = dig_q;
        started_d = started_q;
        buf_d     = buf_q;
        len_d     = len_q;
        idx_d     = idx_q;
        IN_ACK    = 1'b0;
        OUT_STB   = 1'b0;
        OUT_CHAR  = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                if (IN_STB) begin
                    char_d  = IN_CHAR;
                    state_d = ST_ACK;
                end
            end

            ST_ACK: begin
                IN_ACK  = 1'b1;
                state_d = ST_IDLE;
                if (w_is_eq) begin
                    idx_d = 3'd0;
                    if (err_q || (depth_q != 4'd1)) begin
                        buf_d[0] = 8'h45;
                        buf_d[1] = 8'h0A;
                        len_d    = 3'd2;
                        state_d  = ST_EMIT;
                    end else begin
                        pidx_d    = 3'd0;
                        dig_d     = 4'd0;
                        started_d = 1'b0;
                        if (w_top[W-1]) begin
                            buf_d[0] = 8'h2D;
                            len_d    = 3'd1;
                            mag_d    = ~w_top_ext + 17'd1;
                        end else begin
                            len_d    = 3'd0;
                            mag_d    = w_top_ext;
                        end
                        state_d = ST_CONV;
                    end
                end else if (!err_q) begin
                    if (w_is_digit) begin
                        if (depth_q == 4'(STACK_DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            stk_d[w_push_idx] = {{(W - 4){1'b0}}, char_q[3:0]};
                            depth_d           = depth_q + 4'd1;
                        end
                    end else if (w_is_arith || w_is_div) begin
                        if (depth_q < 4'd2) begin
                            err_d = 1'b1;
                        end else if (w_is_arith) begin
                            stk_d[w_nxt_idx] = w_arith;
                            depth_d          = depth_q - 4'd1;
                        end else if (w_top == '0) begin
                            err_d = 1'b1;
                        end else begin
                            quo_d   = w_a_mag;
                            rem_d   = '0;
                            dvs_d   = w_b_mag;
                            neg_d   = w_nxt[W-1] ^ w_top[W-1];
                            cnt_d   = '0;
                            state_d = ST_EXEC;
                        end
                    end
                end
            end

            ST_EXEC: begin
                quo_d = w_quo_nx;
                rem_d = w_rem_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    stk_d[w_nxt_idx] = w_quo_res;
                    depth_d          = depth_q - 4'd1;
                    cnt_d            = '0;
                    state_d          = ST_IDLE;
                end
            end

            ST_CONV: begin
                if (pidx_q == 3'd5) begin
                    buf_d[len_q] = 8'h0A;
                    len_d        = len_q + 3'd1;
                    state_d      = ST_EMIT;
                end else if (mag_q >= w_pow) begin
                    mag_d = mag_q - w_pow;
                    dig_d = dig_q + 4'd1;
                end else begin
                    // leading zeros are dropped, but the units digit always prints
                    if ((dig_q != 4'd0) || started_q || (pidx_q == 3'd4)) begin
                        buf_d[len_q] = 8'h30 + {4'h0, dig_q};
                        len_d        = len_q + 3'd1;
                        started_d    = 1'b1;
                    end
                    dig_d  = 4'd0;
                    pidx_d = pidx_q + 3'd1;
                end
            end

            ST_EMIT: begin
                OUT_STB  = 1'b1;
                OUT_CHAR = buf_q[idx_q];
                if (OUT_ACK) begin
                    state_d = ST_WAIT;
                    if (idx_q == (len_q - 3'd1)) begin
                        depth_d = 4'd0;
                        err_d   = 1'b0;
                    end
                end
            end

            ST_WAIT: begin
                // one cycle with OUT_STB low between characters
                if (idx_q == (len_q - 3'd1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_EMIT;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            char_q    <= 8'h00;
            depth_q   <= 4'd0;
            err_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            mag_q     <= '0;
            pidx_q    <= 3'd0;
            dig_q     <= 4'd0;
            started_q <= 1'b0;
            len_q     <= 3'd0;
            idx_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            char_q    <= char_d;
            depth_q   <= depth_d;
            err_q     <= err_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            pidx_q    <= pidx_d;
            dig_q     <= dig_d;
            started_q <= started_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
        end
    end

    // storage arrays carry no reset; occupancy and length gate every read
    always_ff @(posedge CLK) begin
        stk_q <= stk_d;
        buf_q <= buf_d;
    end

    assign ERR   = err_q;
    assign DEPTH = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_rpn_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpn_eval
// Purpose  : Self-checking bench for rpn_eval: fixed expression table,
//            hand-written reset/error sequences, and random expressions
//            compared against a queue-based reference evaluator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpn_eval;

    logic       CLK;
    logic       RST;
    logic       IN_STB;
    logic [7:0] IN_CHAR;
    logic       IN_ACK;
    logic       OUT_STB;
    logic [7:0] OUT_CHAR;
    logic       OUT_ACK;
    logic       ERR;
    logic [3:0] DEPTH;

    int checks   = 0;
    int failures = 0;

    rpn_eval #(.STACK_DEPTH(8), .W(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_STB   (IN_STB),
        .IN_CHAR  (IN_CHAR),
        .IN_ACK   (IN_ACK),
        .OUT_STB  (OUT_STB),
        .OUT_CHAR (OUT_CHAR),
        .OUT_ACK  (OUT_ACK),
        .ERR      (ERR),
        .DEPTH    (DEPTH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else               r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(got), vis(exp));
        end
    endtask

    // ------------------------------------------------------------------
    // Reference evaluator
    // ------------------------------------------------------------------
    function automatic int wrap16(input longint v);
        longint m;
        m = v & longint'(65535);
        return (m >= 32768) ? int'(m - 65536) : int'(m);
    endfunction

    function automatic string ref_model(input string s);
        int         stk[$];
        bit         err = 0;
        string      out = "";
        logic [7:0] c;
        int         a, b;
        longint     r;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c >= 8'h30 && c <= 8'h39) begin
                if (!err) begin
                    if (stk.size() == 8) err = 1;
                    else stk.push_back(int'(c) - 48);
                end
            end else if (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F) begin
                if (!err) begin
                    if (stk.size() < 2) begin
                        err = 1;
                    end else begin
                        b = stk.pop_back();
                        a = stk.pop_back();
                        if (c == 8'h2F && b == 0) begin
                            err = 1;
                            stk.push_back(a);
                            stk.push_back(b);
                        end else begin
                            if (c == 8'h2B)      r = longint'(a) + longint'(b);
                            else if (c == 8'h2D) r = longint'(a) - longint'(b);
                            else if (c == 8'h2A) r = longint'(a) * longint'(b);
                            else                 r = longint'(a) / longint'(b);
                            stk.push_back(wrap16(r));
                        end
                    end
                end
            end else if (c == 8'h3D) begin
                if (err || stk.size() != 1) out = {out, "E\n"};
                else                        out = {out, $sformatf("%0d\n", stk[0])};
                stk.delete();
                err = 0;
            end
        end
        return out;
    endfunction

    // ------------------------------------------------------------------
    // Bus tasks
    // ------------------------------------------------------------------
    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge CLK);
        IN_CHAR = c;
        IN_STB  = 1'b1;
        @(posedge CLK); #1;
        while (!IN_ACK && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        IN_STB = 1'b0;
        chk("in_ack_seen", int'(IN_ACK), 1);
    endtask

    // Collects one '='-emission up to and including the line feed.
    task automatic collect(input int dly, output string got, output bit hs_ok);
        logic [7:0] c;
        int         n;
        int         budget;
        got    = "";
        hs_ok  = 1'b1;
        budget = 60;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!OUT_STB && n < budget) begin
                @(posedge CLK); #1;
                if (IN_ACK) hs_ok = 1'b0;
                n++;
            end
            if (!OUT_STB) begin
                chk("out_stb_timeout", 0, 1);
                return;
            end
            c   = OUT_CHAR;
            got = $sformatf("%s%c", got, c);
            repeat (dly) begin
                @(posedge CLK); #1;
                if (!OUT_STB || OUT_CHAR != c || IN_ACK) hs_ok = 1'b0;
            end
            OUT_ACK = 1'b1;
            @(posedge CLK); #1;
            OUT_ACK = 1'b0;
            if (OUT_STB || IN_ACK) hs_ok = 1'b0;
            budget = 10;
            if (c == 8'h0A) break;
        end
    endtask

    task automatic run_stream(input string s, input int dly, output string out, output bit hs_ok);
        string part;
        bit    ok;
        out   = "";
        hs_ok = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (s[i] == 8'h3D) begin
                collect(dly, part, ok);
                out = {out, part};
                if (!ok) hs_ok = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test table
    // ------------------------------------------------------------------
    typedef struct {
        string stim;
        string exp;
        int    dly;
    } vec_t;

    vec_t vecs[$];

    function automatic string rand_stream();
        string      s;
        int         n, k;
        logic [7:0] ch;
        logic [7:0] ops[4];
        logic [7:0] oth[3];
        ops = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
        oth = '{8'h28, 8'h29, 8'h20};
        s = "";
        n = int'($urandom_range(1, 12));
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 55)      ch = 8'(8'h30 + $urandom_range(0, 9));
            else if (k < 92) ch = ops[$urandom_range(0, 3)];
            else             ch = oth[$urandom_range(0, 2)];
            s = $sformatf("%s%c", s, ch);
        end
        return {s, "="};
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        string out;
        bit    ok;
        string rs;

        RST     = 1'b1;
        IN_STB  = 1'b0;
        IN_CHAR = 8'h00;
        OUT_ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_in_ack",   int'(IN_ACK),   0);
        chk("reset_out_stb",  int'(OUT_STB),  0);
        chk("reset_out_char", int'(OUT_CHAR), 0);
        chk("reset_err",      int'(ERR),      0);
        chk("reset_depth",    int'(DEPTH),    0);
        @(negedge CLK);
        RST = 1'b0;

        // digit push is visible the cycle after IN_ACK
        send_char(8'h33);
        @(posedge CLK); #1;
        chk("digit_depth_next_cycle", int'(DEPTH), 1);
        run_stream("4+=", 0, out, ok);
        chk_str("first_sum", out, "7\n");

        vecs.push_back('{"34+=",          "7\n",      0});
        vecs.push_back('{"12-=",          "-1\n",     0});
        vecs.push_back('{"55-=",          "0\n",      0});
        vecs.push_back('{"99*9*9*9*=",    "-6487\n",  0});
        vecs.push_back('{"50/=",          "E\n",      0});
        vecs.push_back('{"+=",            "E\n",      1});
        vecs.push_back('{"123456789=",    "E\n",      0});
        vecs.push_back('{"84/=",          "2\n",      5});
        vecs.push_back('{"(3)=",          "3\n",      2});
        vecs.push_back('{"0=",            "0\n",      0});
        vecs.push_back('{"11=",           "E\n",      0});
        vecs.push_back('{"88*8*8*8*=",    "-32768\n", 0});
        vecs.push_back('{"88*8*8*8*01-/=", "-32768\n", 3});
        vecs.push_back('{"07-2/=",        "-3\n",     0});
        vecs.push_back('{"97*4-9*=",      "531\n",    1});

        foreach (vecs[i]) begin
            run_stream(vecs[i].stim, vecs[i].dly, out, ok);
            chk_str($sformatf("vec%0d_out", i), out, vecs[i].exp);
            chk($sformatf("vec%0d_handshake", i), int'(ok), 1);
            chk($sformatf("vec%0d_depth", i), int'(DEPTH), 0);
            chk($sformatf("vec%0d_err", i), int'(ERR), 0);
        end

        // divide by zero raises ERR; digits are then ignored
        send_char(8'h35);
        send_char(8'h30);
        send_char(8'h2F);
        @(posedge CLK); #1;
        chk("div0_err", int'(ERR), 1);
        send_char(8'h39);
        @(posedge CLK); #1;
        chk("div0_err_sticky", int'(ERR), 1);
        run_stream("=", 0, out, ok);
        chk_str("div0_emit", out, "E\n");
        chk("div0_err_cleared", int'(ERR), 0);

        // overflow caps the stack at eight entries
        for (int i = 0; i < 9; i++) send_char(8'h31);
        @(posedge CLK); #1;
        chk("ovf_depth", int'(DEPTH), 8);
        chk("ovf_err", int'(ERR), 1);
        send_char(8'h32);
        @(posedge CLK); #1;
        chk("ovf_depth_held", int'(DEPTH), 8);
        run_stream("=", 0, out, ok);
        chk_str("ovf_emit", out, "E\n");
        chk("ovf_depth_cleared", int'(DEPTH), 0);

        // reset while a result character is being offered
        send_char(8'h34);
        send_char(8'h35);
        send_char(8'h2A);
        send_char(8'h3D);
        for (int n = 0; n < 60 && !OUT_STB; n++) begin
            @(posedge CLK); #1;
        end
        chk("mid_emit_out_stb", int'(OUT_STB), 1);
        chk("mid_emit_char", int'(OUT_CHAR), 8'h32);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rst_emit_out_stb", int'(OUT_STB), 0);
        chk("rst_emit_depth", int'(DEPTH), 0);
        chk("rst_emit_out_char", int'(OUT_CHAR), 0);
        @(negedge CLK);
        RST = 1'b0;
        run_stream("7=", 0, out, ok);
        chk_str("after_rst_emit", out, "7\n");

        // reset in the middle of a division
        send_char(8'h38);
        send_char(8'h34);
        send_char(8'h2F);
        repeat (4) @(posedge CLK);
        do_reset();
        #1;
        chk("rst_exec_depth", int'(DEPTH), 0);
        chk("rst_exec_in_ack", int'(IN_ACK), 0);
        run_stream("62/=", 0, out, ok);
        chk_str("after_rst_exec", out, "3\n");

        // random expressions against the reference evaluator
        for (int t = 0; t < 30; t++) begin
            rs = rand_stream();
            run_stream(rs, int'($urandom_range(0, 3)), out, ok);
            chk_str($sformatf("rand%0d_%s", t, rs), out, ref_model(rs));
            chk($sformatf("rand%0d_handshake", t), int'(ok), 1);
            chk($sformatf("rand%0d_depth", t), int'(DEPTH), 0);
            chk($sformatf("rand%0d_err", t), int'(ERR), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
